// File: rtl/bouncy_pkg.sv
// Shared types and constants for the strike sequencer and its helpers.
package bouncy_pkg;

  localparam int unsigned SAMPLE_W = 12;
  localparam int unsigned LEVEL_W  = 3;

  typedef enum logic [1:0] {
    StIdle,
    StFire,
    StRing
  } state_e;

  // Absolute value of a two's-complement sample; the most negative code saturates.
  function automatic logic [SAMPLE_W-1:0] abs_sat(input logic signed [SAMPLE_W-1:0] s);
    logic [SAMPLE_W-1:0] r;
    if (s == {1'b1, {(SAMPLE_W-1){1'b0}}}) begin
      r = {1'b0, {(SAMPLE_W-1){1'b1}}};
    end else if (s[SAMPLE_W-1]) begin
      r = $unsigned(-s);
    end else begin
      r = $unsigned(s);
    end
    return r;
  endfunction

endpackage

// File: rtl/strike_fifo.sv
// Small synchronous FIFO holding pending strike levels; no write-to-read bypass.
module strike_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [Width-1:0] wdata,
  input  logic             pop,
  output logic [Width-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic [PtrW-1:0]  wptr_q, wptr_d;
  logic [PtrW-1:0]  rptr_q, rptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             push_ok, pop_ok;

  assign full    = (cnt_q == CntW'(Depth));
  assign empty   = (cnt_q == '0);
  assign rdata   = mem_q[rptr_q];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push_ok) begin
      mem_d[wptr_q] = wdata;
      wptr_d = (wptr_q == PtrW'(Depth - 1)) ? '0 : wptr_q + PtrW'(1);
    end
    if (pop_ok) begin
      rptr_d = (rptr_q == PtrW'(Depth - 1)) ? '0 : rptr_q + PtrW'(1);
    end
    cnt_d = cnt_q + CntW'(push_ok) - CntW'(pop_ok);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      mem_q  <= mem_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/strike_sequencer.sv
// Queues strike requests, fires them at a resonator, waits for the ring to decay,
// paces physics updates and renders the resonator output as 1-bit PWM.
module strike_sequencer
  import bouncy_pkg::*;
#(
  parameter int unsigned         RATE_W    = 8,
  parameter logic [SAMPLE_W-1:0] QUIET_THR = 12'd64,
  parameter int unsigned         QUIET_CNT = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       strike_valid,
  output logic                       strike_ready,
  input  logic [LEVEL_W-1:0]         strike_level,
  input  logic [RATE_W-1:0]          rate,
  input  logic signed [SAMPLE_W-1:0] sample,
  output logic [LEVEL_W-1:0]         trigger,
  output logic                       update,
  output logic                       pwm,
  output logic                       busy
);

  localparam int unsigned QW = $clog2(QUIET_CNT + 1);

  state_e             state_q, state_d;
  logic [LEVEL_W-1:0] trigger_q, trigger_d;
  logic               update_q, update_d;
  logic               busy_q, busy_d;
  logic               pwm_q, pwm_d;
  logic [RATE_W-1:0]  div_q, div_d;
  logic [QW-1:0]      quiet_q, quiet_d;
  logic [7:0]         cnt_q, cnt_d;

  logic               fifo_full, fifo_empty, push, pop, div_hit;
  logic [LEVEL_W-1:0] fifo_head;
  logic [7:0]         duty;

  assign strike_ready = !fifo_full;
  // Zero-level requests complete the handshake but are dropped.
  assign push         = strike_valid && strike_ready && (strike_level != '0);
  assign pop          = (state_q == StFire);

  strike_fifo #(
    .Depth(4),
    .Width(LEVEL_W)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .wdata(strike_level),
    .pop  (pop),
    .rdata(fifo_head),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  // Next-state for the FSM, quiet counter, divider and PWM; all outputs registered.
  always_comb begin
    state_d = state_q;
    quiet_d = quiet_q;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) state_d = StFire;
      end
      StFire: begin
        quiet_d = '0;
        state_d = StRing;
      end
      StRing: begin
        if (update_q) begin
          if (abs_sat(sample) < QUIET_THR) quiet_d = quiet_q + QW'(1);
          else                             quiet_d = '0;
        end
        // A full queue retriggers even if the ring has just gone quiet.
        if (fifo_full)                     state_d = StFire;
        else if (quiet_d == QW'(QUIET_CNT)) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Head is stable until the FIRE cycle pops it, so it can be latched one cycle early.
    trigger_d = (state_d == StFire) ? fifo_head : '0;
    busy_d    = (state_d != StIdle);

    // >= keeps the divider sane if rate is lowered mid-count.
    div_hit  = (div_q >= rate);
    div_d    = div_hit ? '0 : div_q + RATE_W'(1);
    update_d = div_hit && (trigger_d == '0);

    duty  = sample[SAMPLE_W-1 -: 8] ^ 8'h80;
    cnt_d = cnt_q + 8'd1;
    pwm_d = (cnt_q < duty);
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      trigger_q <= '0;
      update_q  <= 1'b0;
      busy_q    <= 1'b0;
      pwm_q     <= 1'b0;
      div_q     <= '0;
      quiet_q   <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      trigger_q <= trigger_d;
      update_q  <= update_d;
      busy_q    <= busy_d;
      pwm_q     <= pwm_d;
      div_q     <= div_d;
      quiet_q   <= quiet_d;
      cnt_q     <= cnt_d;
    end
  end

  assign trigger = trigger_q;
  assign update  = update_q;
  assign busy    = busy_q;
  assign pwm     = pwm_q;

endmodule
